// File: rtl/cnn_sched_pkg.sv
// Shared state type, per-layer shape table and BRAM index constants for cnn_layer_sched.
package cnn_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    FIRE,
    WAIT,
    FIN
  } sched_state_e;

  localparam logic [1:0] W1  = 2'd0;
  localparam logic [1:0] W2  = 2'd1;
  localparam logic [1:0] W3  = 2'd2;
  localparam logic       IF1 = 1'b0;
  localparam logic       IF2 = 1'b1;

  localparam logic [5:0] C1_IN_DIM = 6'd32;
  localparam logic [4:0] C1_IN_CH  = 5'd1;
  localparam logic [6:0] C1_OUT_CH = 7'd6;
  localparam logic [5:0] C2_IN_DIM = 6'd14;
  localparam logic [4:0] C2_IN_CH  = 5'd6;
  localparam logic [6:0] C2_OUT_CH = 7'd16;
  localparam logic [5:0] C3_IN_DIM = 6'd5;
  localparam logic [4:0] C3_IN_CH  = 5'd16;
  localparam logic [6:0] C3_OUT_CH = 7'd120;

  typedef struct packed {
    logic [5:0] in_dim;
    logic [4:0] in_ch;
    logic [6:0] out_ch;
  } layer_shape_t;

  function automatic layer_shape_t layer_shape(input logic [1:0] idx);
    layer_shape_t s;
    s = '0;
    case (idx)
      2'd0: begin s.in_dim = C1_IN_DIM; s.in_ch = C1_IN_CH; s.out_ch = C1_OUT_CH; end
      2'd1: begin s.in_dim = C2_IN_DIM; s.in_ch = C2_IN_CH; s.out_ch = C2_OUT_CH; end
      2'd2: begin s.in_dim = C3_IN_DIM; s.in_ch = C3_IN_CH; s.out_ch = C3_OUT_CH; end
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic logic [1:0] weight_bram(input logic [1:0] idx);
    case (idx)
      2'd0:    return W1;
      2'd1:    return W2;
      default: return W3;
    endcase
  endfunction

  // Odd layers read the buffer the previous layer wrote, hence the ping-pong on bit 0.
  function automatic logic feature_src(input logic [1:0] idx);
    return idx[0] ? IF2 : IF1;
  endfunction

endpackage

// File: rtl/cnn_layer_sched_if.sv
// Engine launch/config and host BRAM arbitration bundle between cnn_layer_sched and the cnn datapath.
interface cnn_layer_sched_if;

  logic       eng_start;
  logic       eng_done;
  logic [1:0] layer_id;
  logic [1:0] w_sel;
  logic       src_sel;
  logic       dst_sel;
  logic [5:0] cfg_in_dim;
  logic [4:0] cfg_in_ch;
  logic [6:0] cfg_out_ch;
  logic       host_req;
  logic       host_gnt;

  modport master (
    output eng_start, layer_id, w_sel, src_sel, dst_sel,
    output cfg_in_dim, cfg_in_ch, cfg_out_ch, host_gnt,
    input  eng_done, host_req
  );

  modport slave (
    input  eng_start, layer_id, w_sel, src_sel, dst_sel,
    input  cfg_in_dim, cfg_in_ch, cfg_out_ch, host_gnt,
    output eng_done, host_req
  );

endinterface

// File: rtl/sched_cyc_cnt.sv
// Saturating run-cycle counter for cnn_layer_sched; only present when SCHED_CYCLE_CNT_EN is defined.
`ifdef SCHED_CYCLE_CNT_EN
module sched_cyc_cnt #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule
`endif

// File: rtl/cnn_layer_sched.sv
// Layer sequencer: one start runs conv1..conv(NUM_LAYERS) on the shared engine and arbitrates host BRAM access.
// Optional run-cycle counter is built when SCHED_CYCLE_CNT_EN is defined.
module cnn_layer_sched
  import cnn_sched_pkg::*;
#(
  parameter int NUM_LAYERS = 3,
  parameter int CNT_W      = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  cnn_layer_sched_if.master bus,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_proto_err,
  output logic [CNT_W-1:0]  o_cyc_cnt
);

  localparam logic [1:0] LAST_LAYER = 2'(NUM_LAYERS - 1);

  sched_state_e r_state, w_next;
  logic [1:0]   r_layer, w_next_layer;
  layer_shape_t r_shape;
  logic [1:0]   r_w_sel;
  logic         r_src, r_dst, r_err, r_gnt;
  logic         w_idle_or_fin, w_busy, w_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // A start is refused while the host asks for or still holds the BRAMs, so they never overlap the engine.
  always_comb begin
    w_next        = r_state;
    w_next_layer  = r_layer;
    w_idle_or_fin = (r_state == IDLE) || (r_state == FIN);
    w_busy        = (r_state == CFG) || (r_state == FIRE) || (r_state == WAIT);
    w_accept      = w_idle_or_fin && i_start && !bus.host_req && !r_gnt && !i_abort;
    if (i_abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE, FIN: begin
          if (w_accept) begin
            w_next       = CFG;
            w_next_layer = 2'd0;
          end
        end
        CFG:  w_next = FIRE;
        FIRE: w_next = WAIT;
        WAIT: begin
          if (bus.eng_done) begin
            if (r_layer == LAST_LAYER) begin
              w_next = FIN;
            end else begin
              w_next       = CFG;
              w_next_layer = r_layer + 2'd1;
            end
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_layer <= '0;
      r_shape <= '0;
      r_w_sel <= '0;
      r_src   <= 1'b0;
      r_dst   <= 1'b0;
      r_err   <= 1'b0;
      r_gnt   <= 1'b0;
    end else begin
      if (i_abort) begin
        r_layer <= '0;
        r_shape <= '0;
        r_w_sel <= '0;
        r_src   <= 1'b0;
        r_dst   <= 1'b0;
      end else if (w_next == CFG) begin
        r_layer <= w_next_layer;
        r_shape <= layer_shape(w_next_layer);
        r_w_sel <= weight_bram(w_next_layer);
        r_src   <= feature_src(w_next_layer);
        r_dst   <= ~feature_src(w_next_layer);
      end
      // An engine completion is only legal while a layer is in flight; abort masks it.
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (bus.eng_done && !i_abort && (r_state != WAIT)) begin
        r_err <= 1'b1;
      end
      r_gnt <= bus.host_req && w_idle_or_fin;
    end
  end

  assign bus.eng_start  = (r_state == FIRE);
  assign bus.layer_id   = r_layer;
  assign bus.w_sel      = r_w_sel;
  assign bus.src_sel    = r_src;
  assign bus.dst_sel    = r_dst;
  assign bus.cfg_in_dim = r_shape.in_dim;
  assign bus.cfg_in_ch  = r_shape.in_ch;
  assign bus.cfg_out_ch = r_shape.out_ch;
  assign bus.host_gnt   = r_gnt;
  assign o_busy         = w_busy;
  assign o_done         = (r_state == FIN);
  assign o_proto_err    = r_err;

`ifdef SCHED_CYCLE_CNT_EN
  sched_cyc_cnt #(
    .CNT_W (CNT_W)
  ) u_cyc_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_accept),
    .i_inc (w_busy && !i_abort),
    .o_cnt (o_cyc_cnt)
  );
`else
  assign o_cyc_cnt = '0;
`endif

endmodule

// File: tb/tb_cnn_layer_sched.sv
// Randomized self-checking bench for cnn_layer_sched; cycle-count expectations follow SCHED_CYCLE_CNT_EN.
module tb_cnn_layer_sched;

  localparam int CNT_W = 24;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic             iStart = 1'b0;
  logic             iAbort = 1'b0;
  logic             oBusy, oDone, oProtoErr;
  logic [CNT_W-1:0] oCycCnt;

  int nCompared   = 0;
  int nMismatched = 0;
  int startPulses = 0;

  int expInDim[3]  = '{32, 14, 5};
  int expInCh[3]   = '{1, 6, 16};
  int expOutCh[3]  = '{6, 16, 120};

  cnn_layer_sched_if bus ();

  cnn_layer_sched #(
    .NUM_LAYERS (3),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (iStart),
    .i_abort     (iAbort),
    .bus         (bus),
    .o_busy      (oBusy),
    .o_done      (oDone),
    .o_proto_err (oProtoErr),
    .o_cyc_cnt   (oCycCnt)
  );

  always #5 clk = ~clk;

  // Engine-side view: every cycle the launch strobe is seen high counts as one pulse.
  always @(negedge clk) begin
    if (bus.eng_start === 1'b1) startPulses++;
  end

  // Each layer occupies one configure cycle, one launch cycle and (lat+1) waiting cycles.
  function automatic int expectedCount(input int busyCycles);
`ifdef SCHED_CYCLE_CNT_EN
    return busyCycles;
`else
    return 0 * busyCycles;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  task automatic wait_eng_start(output bit found, output int waited);
    found  = 1'b0;
    waited = 0;
    while (!found && waited < 40) begin
      @(negedge clk);
      waited++;
      if (bus.eng_start === 1'b1) found = 1'b1;
    end
  endtask

  // Engine model: sees the launch at the next edge, works lat cycles, then pulses done for one cycle.
  task automatic finish_layer(input int lat, output logic doneAtPulse);
    @(posedge clk);
    repeat (lat) @(posedge clk);
    #1 bus.eng_done = 1'b1;
    @(negedge clk);
    doneAtPulse = oDone;
    @(posedge clk);
    #1 bus.eng_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; iStart = 1'b0; iAbort = 1'b0; bus.eng_done = 1'b0; bus.host_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nCompared++; if ({oBusy, oDone, oProtoErr, bus.eng_start, bus.host_gnt} !== 5'b0) begin nMismatched++; $display("[TB] FAIL reset_flags: got %b want 00000", {oBusy, oDone, oProtoErr, bus.eng_start, bus.host_gnt}); end
    nCompared++; if ({bus.layer_id, bus.w_sel, bus.src_sel, bus.dst_sel} !== 6'b0) begin nMismatched++; $display("[TB] FAIL reset_sel: got %b want 000000", {bus.layer_id, bus.w_sel, bus.src_sel, bus.dst_sel}); end
    nCompared++; if ({bus.cfg_in_dim, bus.cfg_in_ch, bus.cfg_out_ch} !== 18'b0) begin nMismatched++; $display("[TB] FAIL reset_cfg: got %0d/%0d/%0d want 0/0/0", bus.cfg_in_dim, bus.cfg_in_ch, bus.cfg_out_ch); end
    nCompared++; if (oCycCnt !== '0) begin nMismatched++; $display("[TB] FAIL reset_cyc_cnt: got %0d want 0", oCycCnt); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_nominal();
    int   lats[3];
    bit   found;
    int   waited, pulses0, busyCyc;
    logic dAt;
    lats    = '{50, 50, 50};
    busyCyc = 0;
    pulses0 = startPulses;
    pulseStart();
    for (int L = 0; L < 3; L++) begin
      wait_eng_start(found, waited);
      nCompared++; if (!found || waited != 2) begin nMismatched++; $display("[TB] FAIL nominal_launch_latency L%0d: got found=%0b waited=%0d want waited=2", L, found, waited); end
      nCompared++; if (bus.layer_id !== 2'(L) || bus.w_sel !== 2'(L)) begin nMismatched++; $display("[TB] FAIL nominal_layer_wsel L%0d: got %0d/%0d want %0d", L, bus.layer_id, bus.w_sel, L); end
      nCompared++; if (bus.src_sel !== 1'(L % 2) || bus.dst_sel !== ~1'(L % 2)) begin nMismatched++; $display("[TB] FAIL nominal_src_dst L%0d: got %b%b want src=%0d", L, bus.src_sel, bus.dst_sel, L % 2); end
      nCompared++; if (bus.cfg_in_dim !== 6'(expInDim[L]) || bus.cfg_in_ch !== 5'(expInCh[L]) || bus.cfg_out_ch !== 7'(expOutCh[L])) begin nMismatched++; $display("[TB] FAIL nominal_shape L%0d: got %0d/%0d/%0d want %0d/%0d/%0d", L, bus.cfg_in_dim, bus.cfg_in_ch, bus.cfg_out_ch, expInDim[L], expInCh[L], expOutCh[L]); end
      busyCyc += lats[L] + 3;
      finish_layer(lats[L], dAt);
      nCompared++; if (dAt !== 1'b0) begin nMismatched++; $display("[TB] FAIL nominal_done_early L%0d: got %b want 0", L, dAt); end
    end
    nCompared++; if (oDone !== 1'b1 || oBusy !== 1'b0) begin nMismatched++; $display("[TB] FAIL nominal_done_rise: got done=%b busy=%b want 1/0", oDone, oBusy); end
    repeat (10) tick();
    nCompared++; if (startPulses - pulses0 != 3) begin nMismatched++; $display("[TB] FAIL nominal_pulse_count: got %0d want 3", startPulses - pulses0); end
    nCompared++; if (oDone !== 1'b1) begin nMismatched++; $display("[TB] FAIL nominal_done_hold: got %b want 1", oDone); end
    nCompared++; if (oCycCnt !== CNT_W'(expectedCount(busyCyc))) begin nMismatched++; $display("[TB] FAIL nominal_cyc_cnt: got %0d want %0d", oCycCnt, expectedCount(busyCyc)); end
  endtask

  task automatic test_spurious_done();
    bit   found;
    int   waited, pulses0, lat;
    logic dAt;
    pulses0 = startPulses;
    pulseStart();
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    nCompared++; if (oProtoErr !== 1'b1) begin nMismatched++; $display("[TB] FAIL spurious_proto_err: got %b want 1", oProtoErr); end
    for (int L = 0; L < 3; L++) begin
      lat = $urandom_range(0, 20);
      wait_eng_start(found, waited);
      nCompared++; if (!found || waited != ((L == 0) ? 1 : 2) || bus.layer_id !== 2'(L)) begin nMismatched++; $display("[TB] FAIL spurious_layer L%0d: got found=%0b waited=%0d layer=%0d", L, found, waited, bus.layer_id); end
      finish_layer(lat, dAt);
    end
    nCompared++; if (oDone !== 1'b1 || oProtoErr !== 1'b1 || startPulses - pulses0 != 3) begin nMismatched++; $display("[TB] FAIL spurious_completion: got done=%b err=%b pulses=%0d want 1/1/3", oDone, oProtoErr, startPulses - pulses0); end
  endtask

  task automatic test_restart_random();
    bit   found;
    int   waited, pulses0, lat, busyCyc;
    logic dAt;
    for (int run = 0; run < 4; run++) begin
      pulses0 = startPulses;
      busyCyc = 0;
      pulseStart();
      nCompared++; if (oDone !== 1'b0 || oBusy !== 1'b1 || oProtoErr !== 1'b0 || bus.layer_id !== 2'd0) begin nMismatched++; $display("[TB] FAIL restart_entry run%0d: got done=%b busy=%b err=%b layer=%0d want 0/1/0/0", run, oDone, oBusy, oProtoErr, bus.layer_id); end
      nCompared++; if (bus.cfg_out_ch !== 7'(expOutCh[0]) || bus.cfg_in_dim !== 6'(expInDim[0])) begin nMismatched++; $display("[TB] FAIL restart_cfg_settle run%0d: got %0d/%0d want %0d/%0d", run, bus.cfg_in_dim, bus.cfg_out_ch, expInDim[0], expOutCh[0]); end
      for (int L = 0; L < 3; L++) begin
        lat = $urandom_range(0, 15);
        wait_eng_start(found, waited);
        nCompared++; if (!found || waited != 2 || bus.layer_id !== 2'(L) || bus.src_sel !== 1'(L % 2) || bus.cfg_out_ch !== 7'(expOutCh[L])) begin nMismatched++; $display("[TB] FAIL restart_layer run%0d L%0d: got waited=%0d layer=%0d src=%b out_ch=%0d want 2/%0d/%0d/%0d", run, L, waited, bus.layer_id, bus.src_sel, bus.cfg_out_ch, L, L % 2, expOutCh[L]); end
        busyCyc += lat + 3;
        finish_layer(lat, dAt);
      end
      nCompared++; if (oDone !== 1'b1 || startPulses - pulses0 != 3) begin nMismatched++; $display("[TB] FAIL restart_done run%0d: got done=%b pulses=%0d want 1/3", run, oDone, startPulses - pulses0); end
      nCompared++; if (oCycCnt !== CNT_W'(expectedCount(busyCyc))) begin nMismatched++; $display("[TB] FAIL restart_cyc_cnt run%0d: got %0d want %0d", run, oCycCnt, expectedCount(busyCyc)); end
      repeat ($urandom_range(0, 4)) tick();
    end
  endtask

  task automatic test_abort();
    bit   found;
    int   waited, pulses0, lat0, k, busyCyc;
    logic dAt;
    pulses0 = startPulses;
    lat0    = $urandom_range(0, 10);
    k       = $urandom_range(0, 10);
    pulseStart();
    wait_eng_start(found, waited);
    finish_layer(lat0, dAt);
    wait_eng_start(found, waited);
    @(posedge clk);
    #1;
    repeat (k) tick();
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    busyCyc = lat0 + 3 + 2 + k;
    nCompared++; if (oBusy !== 1'b0 || oDone !== 1'b0 || oProtoErr !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_idle: got busy=%b done=%b err=%b want 0/0/0", oBusy, oDone, oProtoErr); end
    nCompared++; if (bus.layer_id !== 2'd0 || bus.cfg_out_ch !== 7'd0 || bus.w_sel !== 2'd0) begin nMismatched++; $display("[TB] FAIL abort_outputs: got layer=%0d out_ch=%0d wsel=%0d want 0", bus.layer_id, bus.cfg_out_ch, bus.w_sel); end
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    nCompared++; if (oProtoErr !== 1'b1) begin nMismatched++; $display("[TB] FAIL abort_late_done_err: got %b want 1", oProtoErr); end
    repeat (20) tick();
    nCompared++; if (startPulses - pulses0 != 2 || oBusy !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_no_relaunch: got pulses=%0d busy=%b want 2/0", startPulses - pulses0, oBusy); end
    nCompared++; if (oCycCnt !== CNT_W'(expectedCount(busyCyc))) begin nMismatched++; $display("[TB] FAIL abort_cyc_frozen: got %0d want %0d", oCycCnt, expectedCount(busyCyc)); end
  endtask

  task automatic test_abort_vs_done();
    bit found;
    int waited;
    pulseStart();
    wait_eng_start(found, waited);
    @(posedge clk);
    #1;
    iAbort = 1'b1; bus.eng_done = 1'b1;
    tick();
    iAbort = 1'b0; bus.eng_done = 1'b0;
    nCompared++; if (oBusy !== 1'b0 || oDone !== 1'b0 || oProtoErr !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_beats_done: got busy=%b done=%b err=%b want 0/0/0", oBusy, oDone, oProtoErr); end
  endtask

  task automatic test_host_arb();
    bit   found;
    int   waited, pulses0;
    logic dAt;
    pulses0 = startPulses;
    bus.host_req = 1'b1; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    nCompared++; if (bus.host_gnt !== 1'b1 || oBusy !== 1'b0) begin nMismatched++; $display("[TB] FAIL host_grant_vs_start: got gnt=%b busy=%b want 1/0", bus.host_gnt, oBusy); end
    iStart = 1'b1;
    repeat (3) tick();
    bus.host_req = 1'b0;
    tick();
    iStart = 1'b0;
    nCompared++; if (bus.host_gnt !== 1'b0 || oBusy !== 1'b0 || startPulses != pulses0) begin nMismatched++; $display("[TB] FAIL host_start_blocked: got gnt=%b busy=%b pulses=%0d want 0/0/0", bus.host_gnt, oBusy, startPulses - pulses0); end
    pulseStart();
    nCompared++; if (oBusy !== 1'b1) begin nMismatched++; $display("[TB] FAIL host_start_after_release: got busy=%b want 1", oBusy); end
    bus.host_req = 1'b1;
    for (int L = 0; L < 3; L++) begin
      wait_eng_start(found, waited);
      nCompared++; if (!found || bus.host_gnt !== 1'b0) begin nMismatched++; $display("[TB] FAIL host_no_grant_busy L%0d: got found=%0b gnt=%b want 1/0", L, found, bus.host_gnt); end
      finish_layer($urandom_range(0, 8), dAt);
    end
    nCompared++; if (oDone !== 1'b1 || bus.host_gnt !== 1'b0) begin nMismatched++; $display("[TB] FAIL host_fin_entry: got done=%b gnt=%b want 1/0", oDone, bus.host_gnt); end
    tick();
    nCompared++; if (bus.host_gnt !== 1'b1) begin nMismatched++; $display("[TB] FAIL host_grant_in_fin: got %b want 1", bus.host_gnt); end
    pulseStart();
    nCompared++; if (oDone !== 1'b1 || oBusy !== 1'b0) begin nMismatched++; $display("[TB] FAIL host_fin_start_ignored: got done=%b busy=%b want 1/0", oDone, oBusy); end
    bus.host_req = 1'b0;
    tick();
    nCompared++; if (bus.host_gnt !== 1'b0 || startPulses - pulses0 != 3) begin nMismatched++; $display("[TB] FAIL host_release: got gnt=%b pulses=%0d want 0/3", bus.host_gnt, startPulses - pulses0); end
  endtask

  task automatic test_async_reset();
    bit found;
    int waited;
    pulseStart();
    wait_eng_start(found, waited);
    @(posedge clk);
    #1;
    repeat (3) tick();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    nCompared++; if ({oBusy, oDone, oProtoErr, bus.eng_start, bus.host_gnt, bus.layer_id, bus.w_sel, bus.src_sel, bus.dst_sel} !== 11'b0) begin nMismatched++; $display("[TB] FAIL async_reset_flags: got %b want 0", {oBusy, oDone, oProtoErr, bus.eng_start, bus.host_gnt, bus.layer_id, bus.w_sel, bus.src_sel, bus.dst_sel}); end
    nCompared++; if ({bus.cfg_in_dim, bus.cfg_in_ch, bus.cfg_out_ch} !== 18'b0 || oCycCnt !== '0) begin nMismatched++; $display("[TB] FAIL async_reset_cfg_cnt: got %0d/%0d/%0d cnt=%0d want 0", bus.cfg_in_dim, bus.cfg_in_ch, bus.cfg_out_ch, oCycCnt); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.eng_done = 1'b0;
    bus.host_req = 1'b0;
    test_reset();
    test_nominal();
    test_spurious_done();
    test_restart_random();
    test_abort();
    test_abort_vs_done();
    test_host_arb();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/cnn_layer_sched.md
# cnn_layer_sched

Layer sequencer for the LeNet-5 accelerator: on a single `start` it runs conv1, conv2 and conv3 back-to-back on the shared convolution engine. For each layer it presents that layer's shape, selects the weight BRAM (W1/W2/W3) and sets the IF1/IF2 ping-pong direction. It then pulses the engine and waits for the engine's completion. It sits between the top-level `start`/`done` pins and the engine/BRAM mux logic inside `cnn`, and grants the host BRAM access only while the engine is idle.

## Interface
- `NUM_LAYERS`, default 3: number of layers sequenced (1..3).
- `CNT_W`, default 24: width of the cycle counter.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: level sampled each cycle; accepted only in IDLE or FIN with `host_req`=0.
- `abort` in 1: forces IDLE on the next edge; takes priority over every other input.
- `eng_done` in 1: one-cycle pulse from the engine when the current layer is complete.
- `host_req` in 1: host requests BRAM access.
- `eng_start` out 1: one-cycle pulse that launches the engine.
- `layer_id` out 2: current layer, 0..NUM_LAYERS-1.
- `w_sel` out 2: weight BRAM index (0=W1, 1=W2, 2=W3); equals `layer_id`.
- `src_sel` out 1: feature source (0=IF1, 1=IF2); equals `layer_id[0]`.
- `dst_sel` out 1: always `~src_sel`.
- `cfg_in_dim` out 6 / `cfg_in_ch` out 5 / `cfg_out_ch` out 7: layer shape. Values are 32/1/6, 14/6/16 and 5/16/120.
- `busy` out 1: high in CFG, FIRE and WAIT.
- `done` out 1: high while in FIN.
- `host_gnt` out 1: registered grant.
- `proto_err` out 1: sticky protocol-error flag.
- `cyc_cnt` out CNT_W: run cycle count (see Configuration).

## Operation
- State IDLE, entered on reset or `abort`, all registered outputs 0:
  - `start`=1 and `host_req`=0 → CFG, with `layer_id`=0.
- State CFG:
  - `cfg_*`, `w_sel`, `src_sel` and `dst_sel` are updated from `layer_id` on entry and stay stable until the next CFG.
  - After 1 cycle → FIRE.
- State FIRE:
  - `eng_start`=1 for exactly this cycle.
  - → WAIT.
- State WAIT:
  - `eng_done`=1 and `layer_id`=NUM_LAYERS-1 → FIN.
  - `eng_done`=1 otherwise → CFG with `layer_id`+1.
- State FIN:
  - `done`=1, held until a new `start` is accepted (→ CFG, `layer_id`=0, `done` drops) or `abort` (→ IDLE).
- `start` while `busy` is ignored.
- `eng_done` outside WAIT, including in the same cycle as FIRE, is ignored and sets `proto_err`. `proto_err` clears only on reset or an accepted `start`.
- Host arbitration:
  - `host_gnt` goes to 1 one cycle after `host_req`=1 while the state is IDLE or FIN.
  - `host_gnt` drops one cycle after `host_req` falls.
  - While `host_gnt`=1 or `host_req`=1, `start` is not accepted, so the host and the engine never overlap.
- `abort` during WAIT: the engine is not re-pulsed. A late `eng_done` arriving in IDLE sets `proto_err`.

## Timing
- Reset values: state IDLE; all outputs 0; `cfg_*` = 0.
- Accepted `start` at edge N: CFG at N+1; `eng_start` high in cycle N+2.
- `eng_done` at edge M: next CFG at M+1; next `eng_start` at M+2. Inter-layer overhead is 2 cycles.
- `done` rises 1 cycle after the final `eng_done`.
- `cfg_*` settle one full cycle before `eng_start`.
- Simultaneous `abort` and `eng_done`: `abort` wins and `proto_err` is not set.
- Simultaneous `start` and `host_req` in IDLE: `start` is rejected and the grant is given.

## Configuration
- `SCHED_CYCLE_CNT_EN` defined:
  - `cyc_cnt` clears when `start` is accepted.
  - It increments every cycle in CFG, FIRE and WAIT, and saturates at all-ones.
  - It holds its value in FIN and IDLE; `abort` freezes it.
- `SCHED_CYCLE_CNT_EN` undefined: `cyc_cnt` is tied to 0 and no counter logic exists.

## Structure
- Package `cnn_sched_pkg` holds:
  - the state enum (IDLE, CFG, FIRE, WAIT, FIN);
  - the per-layer shape constants (in_dim, in_ch, out_ch for conv1..conv3);
  - the BRAM index constants W1/W2/W3 and IF1/IF2.
- One sub-module, `sched_cyc_cnt`: the saturating counter, instantiated only under the macro.

## Test plan
- Nominal run: `start` pulse, then `eng_done` 50 cycles after each `eng_start` → exactly 3 `eng_start` pulses.
  - `layer_id`/`w_sel` sequence 0,1,2; `src_sel` 0,1,0; `cfg_out_ch` 6,16,120.
  - `done` rises 1 cycle after the 3rd `eng_done`; `cyc_cnt`=159 with the macro.
- Spurious `eng_done` in CFG → ignored and `proto_err`=1; the run still completes with `done`=1.
- `abort` in WAIT of layer 1 → IDLE next cycle; `busy`=0, `done`=0; no further `eng_start`.
- `host_req`=1 in IDLE with `start` in the same cycle → `host_gnt`=1 next cycle; `start` is ignored and `eng_start` never pulses.
- Restart from FIN: `start` → `done` drops next cycle; `layer_id`=0, `proto_err` clears, and `eng_start` pulses 2 cycles after the `start` edge.
- Asynchronous `rst` low mid-WAIT → all outputs 0 immediately, without waiting for a clock edge.
